// File: rtl/psg_write_arbiter.sv
// Round-robin two-port write arbiter for the AY-3-8913 register file.
// Serialises (address, value) pairs onto the register file's address/data byte stream.
module psg_write_arbiter #(
    parameter int ADDR_BITS = 4,
    parameter int DATA_BITS = 8,
    parameter int IDLE_ADDR = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [ADDR_BITS-1:0] req_addr0,
    input  logic [ADDR_BITS-1:0] req_addr1,
    input  logic [DATA_BITS-1:0] req_data0,
    input  logic [DATA_BITS-1:0] req_data1,
    output logic [DATA_BITS-1:0] bus_data,
    output logic                 bus_phase,
    output logic                 wr_done,
    output logic                 wr_port
);

    localparam logic [DATA_BITS-1:0] IDLE_BYTE = DATA_BITS'(IDLE_ADDR);

    logic                 phase_q, phase_d;
    logic                 last_grant_q, last_grant_d;
    logic                 busy_q, busy_d;
    logic                 owner_q, owner_d;
    logic [DATA_BITS-1:0] data_hold_q, data_hold_d;
    logic [DATA_BITS-1:0] bus_data_q, bus_data_d;
    logic                 wr_done_q, wr_done_d;
    logic                 wr_port_q, wr_port_d;

    logic                 sel;
    logic                 accept;
    logic [DATA_BITS-1:0] addr_ext;

    // Selection only matters on phase-0 cycles; ready is also held low during reset.
    always_comb begin
        sel = 1'b0;
        case (req_valid)
            2'b10:   sel = 1'b1;
            2'b11:   sel = ~last_grant_q;
            default: sel = 1'b0;
        endcase
        req_ready = '0;
        if (rst_n && !phase_q) begin
            req_ready[sel] = req_valid[sel];
        end
        accept   = |req_ready;
        addr_ext = '0;
        addr_ext[ADDR_BITS-1:0] = sel ? req_addr1 : req_addr0;
    end

    // NOTE: every next-state variable gets a default first, so no path can infer a latch.
    always_comb begin
        phase_d      = ~phase_q;
        last_grant_d = last_grant_q;
        busy_d       = busy_q;
        owner_d      = owner_q;
        data_hold_d  = data_hold_q;
        bus_data_d   = bus_data_q;
        wr_done_d    = 1'b0;
        wr_port_d    = wr_port_q;

        if (!phase_q) begin
            // This edge is the register file's data commit for the slot in flight.
            wr_done_d = busy_q;
            if (busy_q) begin
                wr_port_d = owner_q;
            end
            if (accept) begin
                bus_data_d   = addr_ext;
                data_hold_d  = sel ? req_data1 : req_data0;
                owner_d      = sel;
                busy_d       = 1'b1;
                last_grant_d = sel;
            end else begin
                bus_data_d = IDLE_BYTE;
                busy_d     = 1'b0;
            end
        end else begin
            bus_data_d = busy_q ? data_hold_q : '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; data_hold is a plain
    // register (not a memory), so resetting it alongside the control state is cheap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q      <= 1'b0;
            last_grant_q <= 1'b1;
            busy_q       <= 1'b0;
            owner_q      <= 1'b0;
            data_hold_q  <= '0;
            bus_data_q   <= '0;
            wr_done_q    <= 1'b0;
            wr_port_q    <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            last_grant_q <= last_grant_d;
            busy_q       <= busy_d;
            owner_q      <= owner_d;
            data_hold_q  <= data_hold_d;
            bus_data_q   <= bus_data_d;
            wr_done_q    <= wr_done_d;
            wr_port_q    <= wr_port_d;
        end
    end

    assign bus_data  = bus_data_q;
    assign bus_phase = phase_q;
    assign wr_done   = wr_done_q;
    assign wr_port   = wr_port_q;

endmodule

// File: tb/tb_psg_write_arbiter.sv
// Self-checking bench for psg_write_arbiter: directed scenarios plus random traffic,
// compared against a cycle-scheduled model of writes and a register-file model.
module tb_psg_write_arbiter;

    localparam int IDLE = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [3:0] req_addr0, req_addr1;
    logic [7:0] req_data0, req_data1;
    logic [7:0] bus_data;
    logic       bus_phase;
    logic       wr_done;
    logic       wr_port;

    always #5 clk = ~clk;

    psg_write_arbiter #(.ADDR_BITS(4), .DATA_BITS(8), .IDLE_ADDR(IDLE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr0 (req_addr0),
        .req_addr1 (req_addr1),
        .req_data0 (req_data0),
        .req_data1 (req_data1),
        .bus_data  (bus_data),
        .bus_phase (bus_phase),
        .wr_done   (wr_done),
        .wr_port   (wr_port)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: cycle k counts from reset release; a write accepted in cycle k puts its
    // address on the bus in k+1, its value in k+2 and pulses wr_done in k+3.
    int         cyc;
    bit         m_last;
    int         exp_bus[int];
    int         exp_done[int];
    logic [7:0] rf[16];
    int         rf_addr;
    bit         accepted;
    int         acc_port;
    int         grants[$];
    int         done_cycles[$];
    int         wait_c[2];
    int         max_wait;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        cyc     = 0;
        m_last  = 1'b1;
        exp_bus.delete();
        exp_done.delete();
        for (int i = 0; i < 16; i++) rf[i] = 8'h00;
        rf_addr   = 0;
        accepted  = 1'b0;
        wait_c[0] = 0;
        wait_c[1] = 0;
    endtask

    // One clock cycle: check outputs mid-cycle, advance the model, cross the edge.
    task automatic step();
        logic [1:0] er;
        int ph, sel, eb;
        @(negedge clk);
        ph = cyc % 2;
        er = 2'b00;
        if (ph == 0 && req_valid != 2'b00) begin
            if (req_valid == 2'b01)      sel = 0;
            else if (req_valid == 2'b10) sel = 1;
            else                         sel = m_last ? 0 : 1;
            er[sel] = 1'b1;
        end
        eb = exp_bus.exists(cyc) ? exp_bus[cyc] : ((ph == 1) ? IDLE : 0);
        chk("bus_phase", bus_phase, ph);
        chk("req_ready", req_ready, er);
        chk("bus_data", bus_data, eb);
        chk("wr_done", wr_done, exp_done.exists(cyc));
        if (exp_done.exists(cyc)) chk("wr_port", wr_port, exp_done[cyc]);
        if (wr_done === 1'b1) done_cycles.push_back(cyc);

        accepted = 1'b0;
        if (er != 2'b00) begin
            acc_port = er[1] ? 1 : 0;
            accepted = 1'b1;
            m_last   = er[1];
            grants.push_back(acc_port);
            exp_bus[cyc+1]  = acc_port ? req_addr1 : req_addr0;
            exp_bus[cyc+2]  = acc_port ? req_data1 : req_data0;
            exp_done[cyc+3] = acc_port;
        end
        for (int p = 0; p < 2; p++) begin
            if (req_valid[p] && !er[p]) wait_c[p]++;
            else                        wait_c[p] = 0;
            if (wait_c[p] > max_wait) max_wait = wait_c[p];
        end
        // Register file: latch address on phase-1 edges, write on phase-0 edges.
        if (ph == 1)           rf_addr = bus_data[3:0];
        else if (rf_addr < 14) rf[rf_addr] = bus_data;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_write(input int port, input logic [3:0] a, input logic [7:0] d, output int n);
        if (port == 0) begin req_addr0 = a; req_data0 = d; end
        else           begin req_addr1 = a; req_data1 = d; end
        req_valid[port] = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!(accepted && acc_port == port) && n < 8);
        chk("accept_within_budget", (accepted && acc_port == port), 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, g0, nd;
        logic [7:0] snap[16];

        rst_n = 1'b0;
        req_valid = 2'b11;
        req_addr0 = 4'h3; req_addr1 = 4'h4;
        req_data0 = 8'h11; req_data1 = 8'h22;
        max_wait = 0;
        model_reset();

        // Reset values, with both requesters valid to show ready is suppressed.
        #2;
        chk("rst_bus_data", bus_data, 0);
        chk("rst_bus_phase", bus_phase, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_wr_done", wr_done, 0);
        chk("rst_wr_port", wr_port, 0);
        repeat (2) @(posedge clk);
        #1;
        req_valid = 2'b00;
        rst_n = 1'b1;
        model_reset();

        // Idle pattern.
        repeat (8) step();

        // Port 0 writes reg 0 = 0xA5, raised during a phase-1 cycle.
        if (cyc % 2 == 0) step();
        do_write(0, 4'h0, 8'hA5, n);
        chk("ready_latency_cycles", n, 2);
        req_valid = 2'b00;
        repeat (4) step();
        chk("rf_reg0", rf[0], 8'hA5);

        // Contention from a fresh reset: port 0 regs 1..4, port 1 regs 8..11.
        do_reset();
        max_wait = 0;
        g0 = grants.size();
        req_addr0 = 4'd1; req_addr1 = 4'd8;
        req_data0 = 8'($urandom); req_data1 = 8'($urandom);
        req_valid = 2'b11;
        for (int i = 0; i < 40; i++) begin
            step();
            if (accepted) begin
                if (acc_port == 0) begin
                    req_addr0 = (req_addr0 == 4'd4) ? 4'd1 : req_addr0 + 4'd1;
                    req_data0 = 8'($urandom);
                end else begin
                    req_addr1 = (req_addr1 == 4'd11) ? 4'd8 : req_addr1 + 4'd1;
                    req_data1 = 8'($urandom);
                end
            end
        end
        req_valid = 2'b00;
        repeat (4) step();
        chk("contention_accepts", grants.size() - g0, 20);
        for (int i = 0; i < 20 && g0 + i < grants.size(); i++)
            chk("alternating_grant", grants[g0+i], i % 2);
        chk("max_wait_le_3", (max_wait <= 3), 1);

        // Port 1 changes its data right after the accept edge.
        do_write(1, 4'd9, 8'h3C, n);
        req_data1 = 8'hFF;
        req_valid = 2'b00;
        repeat (4) step();
        chk("rf_reg9_held_value", rf[9], 8'h3C);

        // Reset in the cycle after an accept: the write must vanish.
        do_write(0, 4'd5, 8'h12, n);
        req_valid = 2'b11;
        rst_n = 1'b0;
        #1;
        chk("midrst_bus_data", bus_data, 0);
        chk("midrst_bus_phase", bus_phase, 0);
        chk("midrst_req_ready", req_ready, 0);
        chk("midrst_wr_done", wr_done, 0);
        chk("midrst_wr_port", wr_port, 0);
        repeat (2) begin
            @(negedge clk);
            chk("midrst_no_wr_done", wr_done, 0);
        end
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        rst_n = 1'b1;
        model_reset();
        nd = done_cycles.size();
        repeat (6) step();
        chk("midrst_no_done_after", done_cycles.size() - nd, 0);

        // Reg 15 (unimplemented) then reg 13, back to back.
        for (int i = 0; i < 16; i++) snap[i] = rf[i];
        nd = done_cycles.size();
        do_write(0, 4'd15, 8'h77, n);
        do_write(0, 4'd13, 8'h0B, n);
        chk("back_to_back_cycles", n, 2);
        req_valid = 2'b00;
        repeat (4) step();
        for (int i = 0; i < 16; i++)
            if (i != 13) chk("reg15_write_no_effect", rf[i], snap[i]);
        chk("env_ctrl_bits", rf[13][3:0], 4'b1011);
        chk("two_done_pulses", done_cycles.size() - nd, 2);
        if (done_cycles.size() >= nd + 2)
            chk("done_spacing", done_cycles[nd+1] - done_cycles[nd], 2);

        // Random traffic.
        max_wait = 0;
        for (int i = 0; i < 200; i++) begin
            req_valid = 2'($urandom);
            req_addr0 = 4'($urandom); req_addr1 = 4'($urandom);
            req_data0 = 8'($urandom); req_data1 = 8'($urandom);
            step();
        end
        req_valid = 2'b00;
        repeat (4) step();
        chk("random_max_wait_le_3", (max_wait <= 3), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/psg_write_arbiter.md
# psg_write_arbiter

Two-port write arbiter and sequencer for the AY-3-8913 PSG register file. It accepts (register, value) write requests from two requesters, port 0 (host/pin interface) and port 1 (on-chip song player). Requests are granted round-robin and serialised onto the register file's shared 8-bit input. Output bytes follow the register file's free-running address/data alternation: address on the odd phase, data on the even phase. Its `bus_data` output drives the register file's `ui_in` directly.

## Interface
Parameters:
- `ADDR_BITS`, 4, register-address width.
- `DATA_BITS`, 8, register-value width and bus width.
- `IDLE_ADDR`, 15, address driven when no write is in flight. It must be an unimplemented register (14 or 15).

Ports:
- `clk` in 1: single clock, shared with the register file.
- `rst_n` in 1: asynchronous, active-low reset. The same net resets the register file. Deassertion is synchronous to `clk` at top level.
- `req_valid` in 2: per-port write request (bit 0 = port 0).
- `req_ready` out 2: per-port accept, combinational.
- `req_addr0`, `req_addr1` in ADDR_BITS: target register per port.
- `req_data0`, `req_data1` in DATA_BITS: value per port.
- `bus_data` out DATA_BITS: registered byte to the register file input.
- `bus_phase` out 1: registered copy of the register file's internal latch toggle. 1 = address phase, 0 = data phase.
- `wr_done` out 1: one-cycle pulse, high in the cycle after the register file commits a write.
- `wr_port` out 1: port that owns the write flagged by `wr_done`. Valid only while `wr_done` is high.

## Operation
- `phase` register:
  - Resets to 0.
  - Toggles on every clock edge with no enable.
  - Stays cycle-identical to the register file's latch. `bus_phase` = `phase`.
- Arbitration happens only in cycles where `phase` = 0 (slot boundary):
  - One requester valid: it is selected.
  - Both valid: the port not granted last is selected.
  - `last_grant` resets to 1, so port 0 wins the first tie.
  - `last_grant` updates only on an accepted request.
- `req_ready[i]` is high iff `phase` = 0, `req_valid[i]` = 1, and port i is selected.
  - At most one ready bit is high at a time.
  - `req_ready` is never high while `phase` = 1.
  - Ready does not depend on anything else. No back-pressure from the register file.
- Accept (edge with valid & ready, `phase` = 0):
  - `bus_data` <= zero-extended address.
  - Selected data is captured into `data_hold`.
  - `owner` <= port; `busy` <= 1.
- Idle slot (edge with `phase` = 0 and no accept):
  - `bus_data` <= zero-extended `IDLE_ADDR`.
  - `busy` <= 0.
- Edge with `phase` = 1:
  - If `busy`: `bus_data` <= `data_hold`.
  - Otherwise: `bus_data` <= 0. This writes 0 to the idle register, which has no effect.
- `wr_done` is raised in the cycle following the register file's data-commit edge of a busy slot. `wr_port` = `owner`.
- Requesters hold `req_addr` and `req_data` stable only until the accept edge. Later changes do not affect the in-flight write.
- Address bits above `ADDR_BITS` on `bus_data` are always 0.

## Timing
- Reset values, all applied asynchronously on `rst_n` low:
  - `phase` 0, `bus_data` 0x00, `data_hold` 0, `busy` 0, `last_grant` 1.
  - `wr_done` 0, `wr_port` 0, `req_ready` 0.
- Edge E0 (`phase` 0, accept) starts a write:
  - Cycle after E0: `phase` 1, `bus_data` = address. Register file latches the address at E1.
  - Cycle after E1: `phase` 0, `bus_data` = value. Register file writes at E2.
  - `wr_done` is high in the cycle after E2.
  - Accept-to-commit latency: 2 edges.
- Throughput: one write every 2 cycles. Back-to-back accepts occur at E0, E2, E4, ...
- Both ports continuously valid: grants alternate 0, 1, 0, 1 ...
- First edge after reset release is a data-phase edge. `bus_data` = 0x00 writes 0 to register 0, which equals its reset value, so there is no corruption.
- Reset mid-write (after accept, before E2): the write is dropped and no `wr_done` is issued. The register file resets in the same window, so the two remain phase-consistent.
- A request arriving while `phase` = 1 waits at most one cycle for its slot. With contention it waits at most 3 cycles.

## Test plan
- Reset release, no requests:
  - `bus_phase` toggles 0, 1, 0, ... from reset.
  - `bus_data` alternates 0x0F on address phases and 0x00 on data phases.
  - `req_ready` = 0.
- Port 0 writes reg 0 = 0xA5, valid raised while `phase` = 1:
  - Ready goes high the next cycle.
  - `bus_data` = 0x00 then 0xA5.
  - `wr_done` = 1 with `wr_port` = 0, exactly 2 edges after accept.
  - Register-file model holds 0xA5 in reg 0.
- Both ports valid continuously, port 0 cycling regs 1..4, port 1 cycling regs 8..11:
  - Grants alternate starting with port 0.
  - One write per 2 cycles.
  - No request is starved for more than one slot.
- Port 1 changes `req_data1` from 0x3C to 0xFF in the cycle after accept: the register file receives 0x3C.
- Assert `rst_n` low in the cycle after an accept:
  - Outputs return to reset values immediately, with no clock edge needed.
  - No `wr_done` is issued.
  - After release, the idle pattern resumes with phase starting at 0.
- Port 0 writes reg 15 = 0x77, then reg 13 = 0x0B:
  - The reg 15 write changes no register.
  - Envelope control bits = 4'b1011.
  - Two `wr_done` pulses occur, 2 cycles apart.
